// File: rtl/md_rom_loader.sv
// md_rom_loader: packs the iosys byte stream into SDRAM words behind a small FIFO.
// Optional header checksum output is enabled with `define LOADER_CKSUM_EN.
module md_rom_loader #(
    parameter int                ADDR_W     = 22,
    parameter int                WORD_BYTES = 2,
    parameter bit                BIG_ENDIAN = 1'b1,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] SAVE_BASE  = 22'h020000
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [2:0]                             loading,
    input  logic [7:0]                             loader_do,
    input  logic                                   loader_do_valid,
    output logic [ADDR_W-$clog2(WORD_BYTES)-1:0]   mem_addr,
    output logic [8*WORD_BYTES-1:0]                mem_din,
    output logic [WORD_BYTES-1:0]                  mem_be,
    output logic                                   mem_req,
    input  logic                                   mem_ack,
    output logic                                   core_on,
    output logic [ADDR_W-1:0]                      rom_size,
    output logic                                   busy,
    output logic                                   overflow
`ifdef LOADER_CKSUM_EN
    ,
    output logic [15:0]                            cksum
`endif
);

    localparam int LB   = $clog2(WORD_BYTES);
    localparam int WA_W = ADDR_W - LB;
    localparam int DW   = 8 * WORD_BYTES;
    localparam int PW   = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                state;
    logic [2:0]            loading_r;
    logic                  act_r;
    logic [2:0]            target;
    logic [ADDR_W-1:0]     cnt;
    logic [DW-1:0]         pack_d;
    logic [WORD_BYTES-1:0] pack_be;
    logic [WA_W-1:0]       pack_addr;

    logic [WA_W-1:0]       f_addr [FIFO_DEPTH];
    logic [DW-1:0]         f_din  [FIFO_DEPTH];
    logic [WORD_BYTES-1:0] f_be   [FIFO_DEPTH];
    logic [PW-1:0]         wp;
    logic [PW-1:0]         rp;
    logic [PW:0]           fcnt;

    logic                  rise;
    logic                  fall;
    logic                  take_byte;
    logic [LB-1:0]         lane;
    logic                  last_lane;
    logic [DW-1:0]         byte_word;
    logic [WORD_BYTES-1:0] byte_be;
    logic [ADDR_W-1:0]     base;
    logic                  push_v;
    logic [WA_W-1:0]       push_addr;
    logic [DW-1:0]         push_din;
    logic [WORD_BYTES-1:0] push_be;
    logic                  pop;
    logic                  full;
    logic                  wr;
    logic                  drop;

    always_comb begin
        rise      = (loading_r != 3'd0) && !act_r;
        fall      = (loading_r == 3'd0) && act_r;
        take_byte = (state == S_LOAD) && loader_do_valid;
        lane      = cnt[LB-1:0];
        last_lane = (lane == LB'(WORD_BYTES - 1));
        base      = (target == 3'd2) ? SAVE_BASE : '0;
        byte_word = pack_d;
        byte_be   = pack_be;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (LB'(BIG_ENDIAN ? WORD_BYTES - 1 - i : i) == lane) begin
                byte_word[8*i +: 8] = loader_do;
                byte_be[i]          = 1'b1;
            end
        end

        push_v    = 1'b0;
        push_addr = pack_addr;
        push_din  = byte_word;
        push_be   = byte_be;
        if (take_byte && last_lane) begin
            push_v = 1'b1;
        end else if (state == S_FLUSH && pack_be != '0) begin
            push_v   = 1'b1;
            push_din = pack_d;
            push_be  = pack_be;
        end

        pop  = (fcnt != '0) && (mem_req == mem_ack);
        full = (fcnt == (PW+1)'(FIFO_DEPTH));
        // a pop in the same cycle frees the slot, so a full FIFO still accepts
        wr   = push_v && (!full || pop);
        drop = push_v && !wr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            loading_r <= '0;
            act_r     <= 1'b0;
            target    <= '0;
            cnt       <= '0;
            pack_d    <= '0;
            pack_be   <= '0;
            pack_addr <= '0;
            wp        <= '0;
            rp        <= '0;
            fcnt      <= '0;
            mem_addr  <= '0;
            mem_din   <= '0;
            mem_be    <= '0;
            mem_req   <= 1'b0;
            core_on   <= 1'b0;
            rom_size  <= '0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
`ifdef LOADER_CKSUM_EN
            cksum     <= '0;
`endif
        end else begin
            loading_r <= loading;
            act_r     <= (loading_r != 3'd0);

            if (wr) begin
                f_addr[wp] <= push_addr;
                f_din[wp]  <= push_din;
                f_be[wp]   <= push_be;
                wp         <= wp + PW'(1);
            end
            if (pop) begin
                mem_addr <= f_addr[rp];
                mem_din  <= f_din[rp];
                mem_be   <= f_be[rp];
                mem_req  <= ~mem_req;
                rp       <= rp + PW'(1);
            end
            case ({wr, pop})
                2'b10:   fcnt <= fcnt + (PW+1)'(1);
                2'b01:   fcnt <= fcnt - (PW+1)'(1);
                default: fcnt <= fcnt;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (rise && (loading_r == 3'd1 || loading_r == 3'd2)) begin
                        state    <= S_LOAD;
                        target   <= loading_r;
                        cnt      <= '0;
                        pack_d   <= '0;
                        pack_be  <= '0;
                        overflow <= 1'b0;
                        core_on  <= 1'b0;
                        busy     <= 1'b1;
`ifdef LOADER_CKSUM_EN
                        if (loading_r == 3'd1) begin
                            cksum <= '0;
                        end
`endif
                    end
                end
                S_LOAD: begin
                    if (take_byte) begin
                        pack_d  <= last_lane ? '0 : byte_word;
                        pack_be <= last_lane ? '0 : byte_be;
                        if (lane == '0) begin
                            pack_addr <= WA_W'((cnt + base) >> LB);
                        end
                        cnt <= cnt + ADDR_W'(1);
`ifdef LOADER_CKSUM_EN
                        // even offsets feed the high half, so a trailing byte lands as {b, 00}
                        if (target == 3'd1 && cnt >= ADDR_W'(12'h200)) begin
                            cksum <= cksum + (cnt[0] ? {8'h00, loader_do}
                                                     : {loader_do, 8'h00});
                        end
`endif
                    end
                    if (fall) begin
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (pack_be != '0) begin
                        pack_d  <= '0;
                        pack_be <= '0;
                    end else if (fcnt == '0 && mem_req == mem_ack) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (target == 3'd1) begin
                        rom_size <= cnt;
                    end
                    core_on <= 1'b1;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_rom_loader.sv
// Directed bench for md_rom_loader with a toggle-handshake SDRAM model and
// a scoreboard of expected writes; the checksum step runs with LOADER_CKSUM_EN.
module tb_md_rom_loader;

    localparam int ADDR_W = 22;
    localparam int WA_W   = 21;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [2:0]        loading = 3'd0;
    logic [7:0]        loader_do = 8'h00;
    logic              loader_do_valid = 1'b0;
    logic [WA_W-1:0]   mem_addr;
    logic [15:0]       mem_din;
    logic [1:0]        mem_be;
    logic              mem_req;
    logic              mem_ack = 1'b0;
    logic              core_on;
    logic [ADDR_W-1:0] rom_size;
    logic              busy;
    logic              overflow;
`ifdef LOADER_CKSUM_EN
    logic [15:0]       cksum;
`endif

    always #5 clk = ~clk;

    md_rom_loader dut (
        .clk             (clk),
        .reset           (reset),
        .loading         (loading),
        .loader_do       (loader_do),
        .loader_do_valid (loader_do_valid),
        .mem_addr        (mem_addr),
        .mem_din         (mem_din),
        .mem_be          (mem_be),
        .mem_req         (mem_req),
        .mem_ack         (mem_ack),
        .core_on         (core_on),
        .rom_size        (rom_size),
        .busy            (busy),
        .overflow        (overflow)
`ifdef LOADER_CKSUM_EN
        ,
        .cksum           (cksum)
`endif
    );

    typedef struct packed {
        logic [WA_W-1:0] addr;
        logic [15:0]     din;
        logic [1:0]      be;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  req_cyc = 0;
    int  ack_delay = 3;
    int  ack_cnt = 0;
    bit  pend = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic expect_wr(input logic [WA_W-1:0] a, input logic [15:0] d,
                             input logic [1:0] be);
        wr_t e;
        e.addr = a;
        e.din  = d;
        e.be   = be;
        exp_q.push_back(e);
    endtask

    // one clock; the SDRAM model samples and answers on the falling edge
    task automatic tick();
        wr_t e;
        @(negedge clk);
        cyc++;
        if (reset) begin
            pend    = 1'b0;
            mem_ack = 1'b0;
        end else if (pend) begin
            if (ack_cnt <= 1) begin
                mem_ack = mem_req;
                pend    = 1'b0;
            end else begin
                ack_cnt--;
            end
        end else if (mem_req !== mem_ack) begin
            pend    = 1'b1;
            ack_cnt = ack_delay;
            req_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("extra_write_addr", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                chk("wr_din", 32'(mem_din), 32'(e.din));
                chk("wr_be", 32'(mem_be), 32'(e.be));
            end
        end
    endtask

    task automatic send(input logic [7:0] b);
        loader_do       = b;
        loader_do_valid = 1'b1;
        tick();
        loader_do_valid = 1'b0;
    endtask

    task automatic start(input logic [2:0] t);
        loading = t;
        repeat (4) tick();
    endtask

    task automatic finish_load(input int budget);
        loading = 3'd0;
        for (int i = 0; i < budget && !(core_on && !busy); i++) begin
            tick();
        end
        chk("load_done", {30'd0, busy, core_on}, 32'h1);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int s;
        logic [7:0] b;
        logic [7:0] prev;

        reset = 1'b1;
        repeat (3) tick();
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_din", 32'(mem_din), 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        chk("rst_core_on", 32'(core_on), 32'd0);
        chk("rst_rom_size", 32'(rom_size), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        tick();

        // four-byte ROM load, big-endian packing, with issue latency check
        start(3'd1);
        chk("load_busy", 32'(busy), 32'd1);
        expect_wr(21'h0, 16'h1234, 2'b11);
        expect_wr(21'h1, 16'h5678, 2'b11);
        send(8'h12);
        send(8'h34);
        s = cyc;
        tick();
        chk("issue_latency", 32'(req_cyc), 32'(s + 1));
        send(8'h56);
        send(8'h78);
        finish_load(100);
        chk("rom_size_4", 32'(rom_size), 32'd4);

        // odd length: trailing partial word carries only the high lane
        start(3'd1);
        expect_wr(21'h0, 16'h0102, 2'b11);
        expect_wr(21'h1, 16'h0304, 2'b11);
        expect_wr(21'h2, 16'hAB00, 2'b10);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        send(8'h04);
        send(8'hAB);
        finish_load(100);
        chk("rom_size_5", 32'(rom_size), 32'd5);

        // cartridge RAM goes to the save base and keeps rom_size
        start(3'd2);
        expect_wr(21'h10000, 16'hCAFE, 2'b11);
        send(8'hCA);
        send(8'hFE);
        finish_load(100);
        chk("cart_rom_size", 32'(rom_size), 32'd5);

        // strobes outside a load are ignored
        send(8'h55);
        repeat (6) tick();
        chk("idle_strobe_busy", 32'(busy), 32'd0);
        chk("idle_strobe_size", 32'(rom_size), 32'd5);

        // stalled port: one outstanding + four queued, words 5..7 dropped
        ack_delay = 40;
        start(3'd1);
        chk("ovf_clear_start", 32'(overflow), 32'd0);
        for (int w = 0; w < 5; w++) begin
            expect_wr(WA_W'(w), {8'(2 * w), 8'(2 * w + 1)}, 2'b11);
        end
        for (int i = 0; i < 16; i++) begin
            send(8'(i));
        end
        chk("ovf_set", 32'(overflow), 32'd1);
        finish_load(400);
        chk("ovf_rom_size", 32'(rom_size), 32'd16);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        ack_delay = 3;
        start(3'd1);
        chk("ovf_cleared", 32'(overflow), 32'd0);
        expect_wr(21'h0, 16'hA5A5, 2'b11);
        send(8'hA5);
        send(8'hA5);
        finish_load(100);
        chk("ovf_reload_size", 32'(rom_size), 32'd2);

        // reset while a request is outstanding
        ack_delay = 20;
        start(3'd1);
        expect_wr(21'h0, 16'hBEEF, 2'b11);
        send(8'hBE);
        send(8'hEF);
        repeat (3) tick();
        chk("pend_before_rst", 32'(pend), 32'd1);
        reset   = 1'b1;
        loading = 3'd0;
        tick();
        chk("midrst_req", 32'(mem_req), 32'd0);
        chk("midrst_core_on", 32'(core_on), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        reset     = 1'b0;
        ack_delay = 3;
        exp_q.delete();
        tick();
        start(3'd1);
        expect_wr(21'h0, 16'h1122, 2'b11);
        expect_wr(21'h1, 16'h3344, 2'b11);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        finish_load(100);
        chk("post_rst_size", 32'(rom_size), 32'd4);

`ifdef LOADER_CKSUM_EN
        // header checksum over 0x200..0x203 = 01 02 03 04
        start(3'd1);
        prev = 8'h00;
        for (int i = 0; i < 'h204; i++) begin
            b = (i >= 'h200) ? 8'(i - 'h1FF) : 8'h00;
            if (i % 2 == 1) begin
                expect_wr(WA_W'(i / 2), {prev, b}, 2'b11);
            end
            prev = b;
            send(b);
            repeat (2) tick();
        end
        finish_load(200);
        chk("cksum", 32'(cksum), 32'h0406);
        chk("cksum_rom_size", 32'(rom_size), 32'h204);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
